// File: rtl/multdiv_sched_pkg.sv
// Shared types and constants for the multdiv scheduler.
// No logic. No latency. No backpressure.
// Provides the state encoding, exception codes and default parameters.
package multdiv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } md_state_e;

    localparam logic [31:0] MULT_EXC    = 32'd4;
    localparam logic [31:0] DIV_EXC     = 32'd5;
    localparam logic [4:0]  DEF_EXC_REG = 5'd30;
    localparam int          DEF_MAX_LAT = 40;

endpackage

// File: rtl/md_watchdog.sv
// Clearable saturating cycle counter guarding the multdiv completion wait.
// expired is combinational from the count; it rises MAX_LAT-1 enabled cycles after clr.
// No backpressure; the counter holds at MAX_LAT instead of wrapping.
module md_watchdog #(
    parameter int MAX_LAT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW  = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_LAT);
    localparam logic [CW-1:0] LIM = CW'(MAX_LAT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt >= LIM);

endmodule

// File: rtl/multdiv_scheduler.sv
// Sequences one mult/div at a time and shares the regfile write port with the W stage.
// Issue to IDLE takes 3 cycles plus the multdiv latency; the result writes one cycle after md_ready.
// The front end is stalled while busy; the W stage always wins the write port and is never stalled.
import multdiv_sched_pkg::*;

module multdiv_scheduler #(
    parameter int         MAX_LAT = DEF_MAX_LAT,
    parameter logic [4:0] EXC_REG = DEF_EXC_REG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic        md_mult,
    output logic        md_div,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        stall,
    output logic        busy,
    output logic        timeout_err
);

    md_state_e   state, state_nxt;
    logic        op_div;
    logic [4:0]  op_rd;
    logic [4:0]  res_rd;
    logic [31:0] res_dat;
    logic        capture;
    logic [4:0]  cap_rd;
    logic [31:0] cap_dat;
    logic        wd_expired;

    md_watchdog #(.MAX_LAT(MAX_LAT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == START),
        .en      (state == WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands stay put until the next accepted issue, so the unit sees them stable throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_operandA <= '0;
            md_operandB <= '0;
            op_rd       <= '0;
            op_div      <= 1'b0;
        end else if ((state == IDLE) && issue_valid) begin
            md_operandA <= issue_a;
            md_operandB <= issue_b;
            op_rd       <= issue_rd;
            op_div      <= issue_is_div;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_rd  <= '0;
            res_dat <= '0;
        end else if (capture) begin
            res_rd  <= cap_rd;
            res_dat <= cap_dat;
        end
    end

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        cap_rd      = op_rd;
        cap_dat     = md_result;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (issue_valid) state_nxt = START;
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // Completion beats an expiring watchdog in the same cycle.
                if (md_ready) begin
                    if (md_exception) begin
                        capture   = 1'b1;
                        cap_rd    = EXC_REG;
                        cap_dat   = op_div ? DIV_EXC : MULT_EXC;
                        state_nxt = WRITE;
                    end else if (op_rd != 5'd0) begin
                        capture   = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (wd_expired) begin
                    timeout_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WRITE: begin
                if (!wb_we) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ctrl_writeEnable = wb_we;
        ctrl_writeReg    = wb_rd;
        data_writeReg    = wb_data;
        if ((state == WRITE) && !wb_we) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = res_rd;
            data_writeReg    = res_dat;
        end
    end

    assign md_mult = (state == START) && !op_div;
    assign md_div  = (state == START) && op_div;
    assign busy    = (state != IDLE);
    assign stall   = issue_valid | busy;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler: expected regfile writes go into a queue and a
// negedge monitor pops and compares them; a second instance with MAX_LAT=8 covers the short watchdog.
module tb_multdiv_scheduler;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        issue_valid, issue_is_div;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a, issue_b;
    logic        md_ready, md_exception;
    logic [31:0] md_result;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        md_mult, md_div, ctrl_writeEnable, stall, busy, timeout_err;
    logic [31:0] md_operandA, md_operandB, data_writeReg;
    logic [4:0]  ctrl_writeReg;

    logic        d8_mult, d8_div, d8_we, d8_stall, d8_busy, d8_timeout;
    logic [31:0] d8_opa, d8_opb, d8_wdat;
    logic [4:0]  d8_wreg;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  mult_pulses = 0;
    int  div_pulses = 0;
    int  stall_gap = 0;
    logic d8_we_seen = 1'b0;

    multdiv_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .md_mult(md_mult), .md_div(md_div), .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .stall(stall), .busy(busy), .timeout_err(timeout_err)
    );

    multdiv_scheduler #(.MAX_LAT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
        .md_mult(d8_mult), .md_div(d8_div), .md_operandA(d8_opa), .md_operandB(d8_opb),
        .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ctrl_writeEnable(d8_we), .ctrl_writeReg(d8_wreg), .data_writeReg(d8_wdat),
        .stall(d8_stall), .busy(d8_busy), .timeout_err(d8_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Write-port monitor: every enabled write must match the head of the queue.
    always @(negedge clk) begin
        wr_t e;
        if (md_mult) mult_pulses++;
        if (md_div) div_pulses++;
        if (d8_we) d8_we_seen = 1'b1;
        if (rst_n && ctrl_writeEnable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got r%0d=%0d expected no write", ctrl_writeReg, data_writeReg);
            end else begin
                e = exp_q.pop_front();
                if (ctrl_writeReg !== e.rd || data_writeReg !== e.dat) begin
                    errors++;
                    $display("FAIL write_port: got r%0d=%0d expected r%0d=%0d",
                             ctrl_writeReg, data_writeReg, e.rd, e.dat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait lat cycles after START, present md_ready; returns one cycle after ready.
    task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input logic [31:0] res, input logic exc);
        step();
        issue_valid = 1'b1; issue_is_div = is_div; issue_a = a; issue_b = b; issue_rd = rd;
        @(negedge clk);
        chk("issue_stall", {31'd0, stall}, 1);
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("start_pulse", {31'd0, is_div ? md_div : md_mult}, 1);
        chk("start_opa", md_operandA, a);
        chk("start_opb", md_operandB, b);
        for (int i = 1; i < lat; i++) begin
            step();
            @(negedge clk);
            if (!stall) stall_gap++;
        end
        step();
        md_ready = 1'b1; md_result = res; md_exception = exc;
        @(negedge clk);
        chk("ready_no_timeout", {31'd0, timeout_err}, 0);
        step();
        md_ready = 1'b0; md_exception = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = '0; issue_a = '0; issue_b = '0;
        md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        #3;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_mult", {31'd0, md_mult}, 0);
        chk("rst_timeout", {31'd0, timeout_err}, 0);
        chk("rst_opa", md_operandA, 0);
        chk("rst_we", {31'd0, ctrl_writeEnable}, 0);
        step();
        rst_n = 1'b1;

        // mult 3*7 -> r5, ready 17 cycles after START
        mult_pulses = 0; stall_gap = 0;
        exp_q.push_back('{rd: 5'd5, dat: 32'd21});
        run_op(1'b0, 32'd3, 32'd7, 5'd5, 17, 32'd21, 1'b0);
        @(negedge clk);
        chk("mult_write_busy", {31'd0, busy}, 1);
        step();
        @(negedge clk);
        chk("mult_idle_busy", {31'd0, busy}, 0);
        chk("mult_idle_stall", {31'd0, stall}, 0);
        chk("mult_stall_gaps", stall_gap, 0);
        chk("mult_pulses", mult_pulses, 1);

        // div 100/7 -> r9 while W stage writes r3 for two cycles; a stray issue is ignored
        div_pulses = 0;
        run_op(1'b1, 32'd100, 32'd7, 5'd9, 5, 32'd14, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
        issue_valid = 1'b1; issue_a = 32'd55; issue_rd = 5'd11;
        exp_q.push_back('{rd: 5'd3, dat: 32'd9});
        @(negedge clk);
        step();
        issue_valid = 1'b0;
        exp_q.push_back('{rd: 5'd3, dat: 32'd9});
        @(negedge clk);
        chk("conflict_opa_held", md_operandA, 100);
        chk("conflict_busy", {31'd0, busy}, 1);
        step();
        wb_we = 1'b0;
        exp_q.push_back('{rd: 5'd9, dat: 32'd14});
        @(negedge clk);
        step();
        @(negedge clk);
        chk("conflict_idle", {31'd0, busy}, 0);
        chk("div_pulses", div_pulses, 1);

        // div exception -> r30 = 5
        exp_q.push_back('{rd: 5'd30, dat: 32'd5});
        run_op(1'b1, 32'd20, 32'd0, 5'd7, 4, 32'd0, 1'b1);
        @(negedge clk);
        chk("divexc_busy", {31'd0, busy}, 1);
        step();

        // mult exception to r0 still reports -> r30 = 4
        exp_q.push_back('{rd: 5'd30, dat: 32'd4});
        run_op(1'b0, 32'd2, 32'd2, 5'd0, 3, 32'd0, 1'b1);
        @(negedge clk);
        step();

        // mult to r0, no exception: straight back to IDLE, no write
        run_op(1'b0, 32'd6, 32'd6, 5'd0, 3, 32'd36, 1'b0);
        @(negedge clk);
        chk("rd0_busy", {31'd0, busy}, 0);
        chk("rd0_we", {31'd0, ctrl_writeEnable}, 0);

        // ready on the watchdog's last cycle counts as completion
        exp_q.push_back('{rd: 5'd17, dat: 32'd123});
        run_op(1'b0, 32'd1, 32'd1, 5'd17, 40, 32'd123, 1'b0);
        @(negedge clk);
        chk("edge_ready_busy", {31'd0, busy}, 1);
        step();

        // timeout on both instances: MAX_LAT=8 and MAX_LAT=40
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        d8_we_seen = 1'b0;
        issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd4; issue_a = 32'd8; issue_b = 32'd8;
        step();
        issue_valid = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            step();
            @(negedge clk);
            if (c == 7) chk("t8_early", {31'd0, d8_timeout}, 0);
            if (c == 8) chk("t8_pulse", {31'd0, d8_timeout}, 1);
            if (c == 9) begin
                chk("t8_after_busy", {31'd0, d8_busy}, 0);
                chk("t8_after_pulse", {31'd0, d8_timeout}, 0);
            end
            if (c == 39) chk("t40_early", {31'd0, timeout_err}, 0);
            if (c == 40) chk("t40_pulse", {31'd0, timeout_err}, 1);
            if (c == 41) begin
                chk("t40_after_busy", {31'd0, busy}, 0);
                chk("t40_after_pulse", {31'd0, timeout_err}, 0);
            end
        end
        chk("t8_no_write", {31'd0, d8_we_seen}, 0);

        // async reset in the middle of WAIT, then a late md_ready
        step();
        issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd8; issue_a = 32'd9; issue_b = 32'd3;
        step();
        issue_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_div", {31'd0, md_div}, 0);
        chk("arst_stall", {31'd0, stall}, 0);
        chk("arst_opa", md_operandA, 0);
        step();
        rst_n = 1'b1;
        step();
        md_ready = 1'b1; md_result = 32'd77;
        @(negedge clk);
        chk("arst_ready_busy", {31'd0, busy}, 0);
        step();
        md_ready = 1'b0;
        @(negedge clk);
        chk("arst_no_write", {31'd0, ctrl_writeEnable}, 0);
        step();

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
